instr_mem_access: RTL and testbench



---
 rtl/instr_mem_access_pkg.sv | 39 +++
 rtl/instr_mem_access_lsu_align.sv | 76 +++++++
 rtl/instr_mem_access.sv | 202 ++++++++++++++++++++
 tb/tb_instr_mem_access.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_access_pkg.sv
// Shared types and constants for the memory-access stage.
// Holds the FSM state enum, the LOAD/STORE opcodes, the funct3 encodings
// and the packed payload of a data-memory request.
package instr_mem_access_pkg;

    localparam int unsigned DW       = 32;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned BE_W     = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b000_0011;
    localparam logic [OPC_W-1:0] OPC_STORE = 7'b010_0011;

    localparam logic [FUNCT3_W-1:0] F3_B  = 3'd0;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'd1;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'd2;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'd4;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'd5;

    // Request fields held stable on the dmem port for the whole REQ phase.
    typedef struct packed {
        logic [DW-1:0]   addr;
        logic            we;
        logic [BE_W-1:0] be;
        logic [DW-1:0]   wdata;
    } dmem_req_t;

    function automatic logic is_mem_op(input logic [OPC_W-1:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/instr_mem_access_lsu_align.sv
// Combinational load/store alignment unit.
// Request side: byte enables, lane-shifted store data and the access check
//   (illegal funct3 for the access kind, or address not size-aligned).
// Response side: extracts the addressed lane of a load word and sign- or
//   zero-extends it according to the captured funct3.
// Ports:
//   is_store, funct3, addr_lo, store_data  -> be_c, wdata_c, access_err_c
//   ld_funct3, ld_addr_lo, rdata           -> ld_data_c
module lsu_align #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic            access_err_c,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data_c
);
    import instr_mem_access_pkg::*;

    logic            legal_f3;
    logic            misaligned;
    logic [XLEN-1:0] ld_shift;

    // Request-side byte enables, store lanes and legality.
    always_comb begin
        be_c         = 4'b0000;
        misaligned   = 1'b0;
        legal_f3     = 1'b0;
        access_err_c = 1'b0;
        wdata_c      = store_data << {addr_lo, 3'b000};

        if (is_store) begin
            legal_f3 = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal_f3 = (funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
        end

        // funct3[1:0] encodes the access size for both signed and unsigned loads.
        case (funct3[1:0])
            2'b00: begin
                be_c = 4'b0001 << addr_lo;
            end
            2'b01: begin
                be_c       = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
            end
            default: begin
                be_c       = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
        endcase

        access_err_c = !legal_f3 || misaligned;
    end

    // Response-side lane extraction and extension.
    always_comb begin
        ld_shift  = rdata >> {ld_addr_lo, 3'b000};
        ld_data_c = ld_shift;
        case (ld_funct3)
            F3_B:    ld_data_c = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
            F3_H:    ld_data_c = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            F3_BU:   ld_data_c = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
            F3_HU:   ld_data_c = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
            default: ld_data_c = ld_shift;
        endcase
    end

endmodule

// File: rtl/instr_mem_access.sv
// Memory-access pipeline stage.
// Accepts one instruction per cycle from execute (when not stalled), passes
// non-memory results to writeback after one cycle, and runs LOAD/STORE
// transactions on the data-memory port with a valid/ready request and a
// valid-only response, stalling upstream while a transaction is in flight.
// Ports:
//   clk, rst                                  clock, sync active-high reset
//   ex_valid, instruction_in, alu_in,
//   mem_data_in                               execute-stage outputs
//   mem_stall                                 upstream halt (state != IDLE)
//   dmem_req_valid/ready, dmem_addr, dmem_we,
//   dmem_be, dmem_wdata                       request channel
//   dmem_rsp_valid, dmem_rdata                response channel
//   wb_valid, wb_instruction, wb_data         writeback outputs
//   mem_fault                                 fault pulse
module instr_mem_access #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RSP_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [XLEN-1:0] alu_in,
    input  logic [XLEN-1:0] mem_data_in,
    output logic            mem_stall,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_instruction,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_fault
);
    import instr_mem_access_pkg::*;

    localparam int unsigned CNT_W = $clog2(RSP_TIMEOUT + 1);

    mem_state_t      state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    dmem_req_t       req_q,       req_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] instr_q,     instr_d;
    logic [1:0]      addr_lo_q,   addr_lo_d;
    logic            wb_valid_q,  wb_valid_d;
    logic [XLEN-1:0] wb_instr_q,  wb_instr_d;
    logic [XLEN-1:0] wb_data_q,   wb_data_d;
    logic            fault_q,     fault_d;

    logic [OPC_W-1:0] opcode_in;
    logic             is_store_in;
    logic [3:0]       be_c;
    logic [XLEN-1:0]  wdata_c;
    logic             access_err_c;
    logic [XLEN-1:0]  ld_data_c;

    assign opcode_in   = instruction_in[6:0];
    assign is_store_in = (opcode_in == OPC_STORE);

    // Request decode uses the live execute inputs; load extraction uses the
    // funct3 and byte offset captured at acceptance.
    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .is_store     (is_store_in),
        .funct3       (instruction_in[14:12]),
        .addr_lo      (alu_in[1:0]),
        .store_data   (mem_data_in),
        .be_c         (be_c),
        .wdata_c      (wdata_c),
        .access_err_c (access_err_c),
        .ld_funct3    (instr_q[14:12]),
        .ld_addr_lo   (addr_lo_q),
        .rdata        (dmem_rdata),
        .ld_data_c    (ld_data_c)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_valid_d = req_valid_q;
        instr_d     = instr_q;
        addr_lo_d   = addr_lo_q;
        wb_valid_d  = 1'b0;
        wb_instr_d  = wb_instr_q;
        wb_data_d   = wb_data_q;
        fault_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (is_mem_op(opcode_in)) begin
                        if (access_err_c) begin
                            fault_d = 1'b1;
                        end else begin
                            state_d     = REQ;
                            req_valid_d = 1'b1;
                            req_d.addr  = {alu_in[XLEN-1:2], 2'b00};
                            req_d.we    = is_store_in;
                            req_d.be    = be_c;
                            req_d.wdata = wdata_c;
                            instr_d     = instruction_in;
                            addr_lo_d   = alu_in[1:0];
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_instr_d = instruction_in;
                        wb_data_d  = alu_in;
                    end
                end
            end

            REQ: begin
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (req_q.we) begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        wb_instr_d = instr_q;
                        wb_data_d  = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end

            WAIT: begin
                // A response in the final counted cycle still wins over the timeout.
                if (dmem_rsp_valid) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_instr_d = instr_q;
                    wb_data_d  = ld_data_c;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(RSP_TIMEOUT)) begin
                        fault_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            instr_q     <= '0;
            addr_lo_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_instr_q  <= '0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            instr_q     <= instr_d;
            addr_lo_q   <= addr_lo_d;
            wb_valid_q  <= wb_valid_d;
            wb_instr_q  <= wb_instr_d;
            wb_data_q   <= wb_data_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_stall      = (state_q != IDLE);
    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = req_q.addr;
    assign dmem_we        = req_q.we;
    assign dmem_be        = req_q.be;
    assign dmem_wdata     = req_q.wdata;
    assign wb_valid       = wb_valid_q;
    assign wb_instruction = wb_instr_q;
    assign wb_data        = wb_data_q;
    assign mem_fault      = fault_q;

endmodule

// File: tb/tb_instr_mem_access.sv
// Bench for instr_mem_access: directed vector table, hand-written reset
// sequences and randomized transactions against a behavioural model.
module tb_instr_mem_access;

    localparam int TO = 4;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_ALU   = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam int K_PASS  = 0;
    localparam int K_FAULT = 1;
    localparam int K_ST    = 2;
    localparam int K_LD    = 3;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          rdy;
        int          rsp;
        int          kind;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wbdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] instruction_in, alu_in, mem_data_in;
    logic        mem_stall, dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid;
    logic        wb_valid, mem_fault;
    logic [31:0] wb_instruction, wb_data;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    instr_mem_access #(
        .XLEN(32),
        .RSP_TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .instruction_in (instruction_in),
        .alu_in         (alu_in),
        .mem_data_in    (mem_data_in),
        .mem_stall      (mem_stall),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_instruction (wb_instruction),
        .wb_data        (wb_data),
        .mem_fault      (mem_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h want 0x%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input int f3);
        logic [2:0] f;
        f = 3'(f3);
        return {17'h0, f, 5'd5, op};
    endfunction

    // Reference model: outcome of one instruction from the ISA rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          op, f3, off, sz;
        bit          st, legal;
        logic [63:0] t;
        logic [31:0] x;
        r   = v;
        op  = int'(v.instr[6:0]);
        f3  = int'(v.instr[14:12]);
        off = int'(v.alu[1:0]);
        sz  = 1 << (f3 % 4);
        r.be = '0; r.wdata = '0; r.wbdata = '0;
        if (op != int'(OP_LOAD) && op != int'(OP_STORE)) begin
            r.kind   = K_PASS;
            r.wbdata = v.alu;
            return r;
        end
        st    = (op == int'(OP_STORE));
        legal = st ? (f3 <= 2) : (f3 <= 5 && f3 != 3);
        if (!legal || (off % sz) != 0) begin
            r.kind = K_FAULT;
            return r;
        end
        r.kind  = st ? K_ST : K_LD;
        r.be    = 4'(((1 << sz) - 1) << off);
        t       = 64'(v.sd) << (8 * off);
        r.wdata = t[31:0];
        if (!st) begin
            x = '0;
            for (int i = 0; i < sz; i++) x[8*i +: 8] = v.rdata[8*(off+i) +: 8];
            if (f3 < 4 && sz < 4 && x[8*sz-1])
                for (int j = 8 * sz; j < 32; j++) x[j] = 1'b1;
            r.wbdata = x;
        end
        return r;
    endfunction

    task automatic add(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [31:0] rdata, input int rdy, input int rsp, input int kind,
                       input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] wbdata);
        vec_t v;
        v.instr = instr; v.alu = alu; v.sd = sd; v.rdata = rdata; v.rdy = rdy; v.rsp = rsp;
        v.kind = kind; v.be = be; v.wdata = wdata; v.wbdata = wbdata;
        tbl.push_back(v);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".stall"},     32'(mem_stall),      32'd0);
        chk({tag, ".req_valid"}, 32'(dmem_req_valid), 32'd0);
        chk({tag, ".we"},        32'(dmem_we),        32'd0);
        chk({tag, ".be"},        32'(dmem_be),        32'd0);
        chk({tag, ".addr"},      dmem_addr,           32'd0);
        chk({tag, ".wdata"},     dmem_wdata,          32'd0);
        chk({tag, ".wb_valid"},  32'(wb_valid),       32'd0);
        chk({tag, ".wb_instr"},  wb_instruction,      32'd0);
        chk({tag, ".wb_data"},   wb_data,             32'd0);
        chk({tag, ".fault"},     32'(mem_fault),      32'd0);
    endtask

    // Drives one instruction through acceptance and, for memory ops, plays the
    // memory side: ready after v.rdy REQ cycles, response in WAIT cycle v.rsp
    // (v.rsp >= TO means no response). Upstream holds inputs while stalled.
    task automatic run_op(input vec_t v, input string tag);
        bit got;
        chk({tag, ".idle_before"}, 32'(mem_stall), 32'd0);
        ex_valid = 1'b1; instruction_in = v.instr; alu_in = v.alu; mem_data_in = v.sd;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        tick();
        if (v.kind == K_PASS) begin
            chk({tag, ".wb_valid"}, 32'(wb_valid),  32'd1);
            chk({tag, ".wb_instr"}, wb_instruction, v.instr);
            chk({tag, ".wb_data"},  wb_data,        v.wbdata);
            chk({tag, ".stall"},    32'(mem_stall), 32'd0);
            chk({tag, ".fault"},    32'(mem_fault), 32'd0);
            chk({tag, ".req"},      32'(dmem_req_valid), 32'd0);
            ex_valid = 1'b0;
        end else if (v.kind == K_FAULT) begin
            chk({tag, ".fault"},    32'(mem_fault), 32'd1);
            chk({tag, ".wb_valid"}, 32'(wb_valid),  32'd0);
            chk({tag, ".req"},      32'(dmem_req_valid), 32'd0);
            chk({tag, ".stall"},    32'(mem_stall), 32'd0);
            ex_valid = 1'b0;
        end else begin
            for (int k = 0; k <= v.rdy; k++) begin
                chk({tag, ".req"},      32'(dmem_req_valid), 32'd1);
                chk({tag, ".stall"},    32'(mem_stall),      32'd1);
                chk({tag, ".addr"},     dmem_addr,           {v.alu[31:2], 2'b00});
                chk({tag, ".we"},       32'(dmem_we),        32'(v.kind == K_ST));
                chk({tag, ".be"},       32'(dmem_be),        32'(v.be));
                chk({tag, ".wdata"},    dmem_wdata,          v.wdata);
                chk({tag, ".wb_valid"}, 32'(wb_valid),       32'd0);
                dmem_req_ready = (k == v.rdy);
                dmem_rsp_valid = (k == v.rdy);
                dmem_rdata     = $urandom;
                tick();
            end
            dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
            if (v.kind == K_ST) begin
                chk({tag, ".wb_valid"}, 32'(wb_valid),       32'd1);
                chk({tag, ".wb_instr"}, wb_instruction,      v.instr);
                chk({tag, ".wb_data"},  wb_data,             32'd0);
                chk({tag, ".req_off"},  32'(dmem_req_valid), 32'd0);
                chk({tag, ".stall"},    32'(mem_stall),      32'd1);
                ex_valid = 1'b0;
                tick();
                chk({tag, ".wb_pulse"}, 32'(wb_valid),  32'd0);
                chk({tag, ".stall_end"}, 32'(mem_stall), 32'd0);
            end else begin
                got = 1'b0;
                for (int w = 0; w < TO; w++) begin
                    chk({tag, ".wait_stall"}, 32'(mem_stall),      32'd1);
                    chk({tag, ".wait_req"},   32'(dmem_req_valid), 32'd0);
                    chk({tag, ".wait_wb"},    32'(wb_valid),       32'd0);
                    chk({tag, ".wait_fault"}, 32'(mem_fault),      32'd0);
                    if (w == v.rsp) begin
                        dmem_rsp_valid = 1'b1; dmem_rdata = v.rdata;
                        tick();
                        dmem_rsp_valid = 1'b0;
                        chk({tag, ".wb_valid"}, 32'(wb_valid),  32'd1);
                        chk({tag, ".wb_instr"}, wb_instruction, v.instr);
                        chk({tag, ".wb_data"},  wb_data,        v.wbdata);
                        chk({tag, ".stall"},    32'(mem_stall), 32'd1);
                        ex_valid = 1'b0;
                        tick();
                        chk({tag, ".wb_pulse"},  32'(wb_valid),  32'd0);
                        chk({tag, ".stall_end"}, 32'(mem_stall), 32'd0);
                        got = 1'b1;
                        break;
                    end
                    if (w == TO - 1) ex_valid = 1'b0;
                    dmem_rdata = $urandom;
                    tick();
                end
                if (!got) begin
                    chk({tag, ".to_fault"}, 32'(mem_fault), 32'd1);
                    chk({tag, ".to_stall"}, 32'(mem_stall), 32'd0);
                    chk({tag, ".to_wb"},    32'(wb_valid),  32'd0);
                    dmem_rsp_valid = 1'b1; dmem_rdata = v.rdata;
                    tick();
                    dmem_rsp_valid = 1'b0;
                    chk({tag, ".late_wb"},    32'(wb_valid),  32'd0);
                    chk({tag, ".late_fault"}, 32'(mem_fault), 32'd0);
                    chk({tag, ".late_stall"}, 32'(mem_stall), 32'd0);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        rst = 1'b1; ex_valid = 1'b0; instruction_in = '0; alu_in = '0; mem_data_in = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;

        //   instr             alu           sd            rdata         rdy rsp kind     be       wdata         wbdata
        add(mk(OP_ALU, 0),   32'h7,        32'h0,        32'h0,        0, 0, K_PASS,  4'h0, 32'h0,        32'h7);
        add(mk(OP_STORE, 0), 32'h1003,     32'hA5,       32'h0,        2, 0, K_ST,    4'h8, 32'hA500_0000, 32'h0);
        add(mk(OP_LOAD, 0),  32'h2002,     32'h0,        32'h1280_3456, 0, 0, K_LD,   4'h4, 32'h0,        32'hFFFF_FF80);
        add(mk(OP_LOAD, 4),  32'h2002,     32'h0,        32'h1280_3456, 0, 0, K_LD,   4'h4, 32'h0,        32'h0000_0080);
        add(mk(OP_LOAD, 2),  32'h2001,     32'h0,        32'h0,        0, 0, K_FAULT, 4'h0, 32'h0,        32'h0);
        add(mk(OP_ALU, 0),   32'h1234,     32'h0,        32'h0,        0, 0, K_PASS,  4'h0, 32'h0,        32'h1234);
        add(mk(OP_LOAD, 2),  32'h3000,     32'h0,        32'hDEAD_BEEF, 1, 3, K_LD,   4'hF, 32'h0,        32'hDEAD_BEEF);
        add(mk(OP_LOAD, 2),  32'h4000,     32'h0,        32'h5555_AAAA, 0, 4, K_LD,   4'hF, 32'h0,        32'h0);
        add(mk(OP_LOAD, 1),  32'h2002,     32'h0,        32'h8012_3456, 0, 1, K_LD,   4'hC, 32'h0,        32'hFFFF_8012);
        add(mk(OP_LOAD, 5),  32'h2001,     32'h0,        32'h0,        0, 0, K_FAULT, 4'h0, 32'h0,        32'h0);
        add(mk(OP_STORE, 1), 32'h12,       32'hBEEF,     32'h0,        0, 0, K_ST,    4'hC, 32'hBEEF_0000, 32'h0);
        add(mk(OP_STORE, 2), 32'h8,        32'h1122_3344, 32'h0,       1, 0, K_ST,    4'hF, 32'h1122_3344, 32'h0);
        add(mk(OP_LOAD, 3),  32'h0,        32'h0,        32'h0,        0, 0, K_FAULT, 4'h0, 32'h0,        32'h0);
        add(mk(OP_STORE, 4), 32'h0,        32'h0,        32'h0,        0, 0, K_FAULT, 4'h0, 32'h0,        32'h0);
        add(mk(OP_STORE, 2), 32'h6,        32'h0,        32'h0,        0, 0, K_FAULT, 4'h0, 32'h0,        32'h0);
        add(mk(OP_LOAD, 5),  32'h2002,     32'h0,        32'h8012_3456, 0, 0, K_LD,   4'hC, 32'h0,        32'h0000_8012);
        add(mk(OP_LOAD, 0),  32'h2000,     32'h0,        32'h0000_007F, 2, 2, K_LD,   4'h1, 32'h0,        32'h0000_007F);
        add(mk(OP_STORE, 0), 32'h1001,     32'h1234_56C3, 32'h0,       0, 0, K_ST,    4'h2, 32'h3456_C300, 32'h0);
        add(mk(OP_IMM, 5),   32'hFFFF_FFFF, 32'h0,       32'h0,        0, 0, K_PASS,  4'h0, 32'h0,        32'hFFFF_FFFF);

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for a load response; the late response must not retire.
        ex_valid = 1'b1; instruction_in = mk(OP_LOAD, 2); alu_in = 32'h100; mem_data_in = 32'h0;
        tick();
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("rstwait.in_wait", 32'(mem_stall), 32'd1);
        rst = 1'b1; ex_valid = 1'b0;
        tick();
        chk_reset("rstwait");
        rst = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rsp_valid = 1'b0;
        chk("rstwait.late_wb",    32'(wb_valid),  32'd0);
        chk("rstwait.late_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("rstwait.late_wb2",   32'(wb_valid),  32'd0);

        // Reset while a store request is pending drops the request.
        ex_valid = 1'b1; instruction_in = mk(OP_STORE, 2); alu_in = 32'h40; mem_data_in = 32'h9;
        tick();
        chk("rstreq.req", 32'(dmem_req_valid), 32'd1);
        rst = 1'b1; ex_valid = 1'b0;
        tick();
        chk_reset("rstreq");
        rst = 1'b0;
        tick();
        chk("rstreq.req_after", 32'(dmem_req_valid), 32'd0);
        chk("rstreq.wb_after",  32'(wb_valid),       32'd0);

        // Randomized instructions checked against the model.
        for (int n = 0; n < 250; n++) begin
            logic [6:0] ops[6];
            ops = '{OP_LOAD, OP_STORE, OP_LOAD, OP_STORE, OP_ALU, 7'h37};
            v.instr        = $urandom;
            v.instr[6:0]   = ops[$urandom_range(0, 5)];
            v.instr[14:12] = 3'($urandom_range(0, 7));
            v.alu   = $urandom;
            v.sd    = $urandom;
            v.rdata = $urandom;
            v.rdy   = $urandom_range(0, 3);
            v.rsp   = $urandom_range(0, TO + 1);
            v = model(v);
            run_op(v, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) begin
                ex_valid = 1'b0; instruction_in = $urandom; alu_in = $urandom;
                tick();
                chk($sformatf("rnd%0d.bubble_wb", n),    32'(wb_valid),  32'd0);
                chk($sformatf("rnd%0d.bubble_fault", n), 32'(mem_fault), 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
